// File: rtl/scroll_pkg.sv
// Shared types and helpers for the scroll window engine.
// Build option: define SCROLL_DIR_EN to honour the dir input of scroll_window_engine.
package scroll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_MSG,
    RUN_GAP,
    FLUSH,
    DONE
  } state_e;

  localparam int BLANK_DEFAULT = 0;

  // Width needed to hold a character count from 0 to max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/scroll_shift_window.sv
// DIGITS x CODE_W window shift register with blank clear, bidirectional insert and hold.
// Digit 0 is the rightmost position; DIGITS must be at least 2.
module scroll_shift_window #(
  parameter int DIGITS = 8,
  parameter int CODE_W = 4,
  parameter int BLANK  = 0
) (
  input  logic                       clk_1hz,
  input  logic                       reset,
  input  logic                       en_i,
  input  logic                       clear_i,
  input  logic                       dir_i,
  input  logic [CODE_W-1:0]          code_i,
  output logic [DIGITS*CODE_W-1:0]   window_o
);

  localparam logic [CODE_W-1:0] BLANK_C = CODE_W'(BLANK);

  logic [DIGITS-1:0][CODE_W-1:0] win_q, win_d;

  // dir_i = 0 pushes toward higher digits with entry at digit 0; dir_i = 1 enters at the top digit.
  always_comb begin
    win_d = win_q;
    if (clear_i) begin
      win_d = {DIGITS{BLANK_C}};
    end else if (en_i) begin
      if (dir_i) begin
        win_d = {code_i, win_q[DIGITS-1:1]};
      end else begin
        win_d = {win_q[DIGITS-2:0], code_i};
      end
    end
  end

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      win_q <= {DIGITS{BLANK_C}};
    end else begin
      win_q <= win_d;
    end
  end

  assign window_o = win_q;

endmodule

// File: rtl/scroll_window_engine.sv
// Scroll engine: streams a captured message through a DIGITS-wide window, one step per clk_1hz edge.
// Build option: SCROLL_DIR_EN enables the dir input; without it direction is fixed toward higher digits.
module scroll_window_engine
  import scroll_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int CODE_W     = 4,
  parameter int MAX_LEN    = 16,
  parameter int GAP        = 1,
  parameter int BLANK      = BLANK_DEFAULT,
  parameter int AUTO_START = 1,
  localparam int LEN_W     = len_w(MAX_LEN)
) (
  input  logic                        clk_1hz,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        step_en,
  input  logic                        loop_mode,
  input  logic                        dir,
  input  logic [LEN_W-1:0]            msg_len,
  input  logic [MAX_LEN*CODE_W-1:0]   msg_data,
  output logic [DIGITS*CODE_W-1:0]    window,
  output logic                        busy,
  output logic                        done,
  output logic                        wrap_pulse
);

  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int FLUSH_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CODE_W-1:0] BLANK_C = CODE_W'(BLANK);

  typedef logic [MAX_LEN-1:0][CODE_W-1:0] msg_t;

  state_e             state_q, state_d;
  msg_t               buf_q, msg_arr, cur_buf;
  logic [LEN_W-1:0]   len_q, len_d, rd_q, rd_d;
  logic [LEN_W-1:0]   new_len, cur_len, cur_rd, char_idx;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               loop_q, loop_d, cur_loop, cur_dir;
  logic               wrap_q, wrap_d;
  logic               accept, last_char;
  logic               shift_en, clear_win;
  logic [CODE_W-1:0]  shift_code;

  assign msg_arr = msg_data;
  assign new_len = (msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : msg_len;

  // AUTO_START only stands in for start while IDLE; leaving DONE always needs a real start.
  assign accept = (((state_q == IDLE) && (start || (AUTO_START != 0))) ||
                   ((state_q == DONE) && start)) && (msg_len != '0);

  // On the accepting edge the freshly sampled inputs drive the first step directly.
  assign cur_len  = accept ? new_len   : len_q;
  assign cur_rd   = accept ? '0        : rd_q;
  assign cur_loop = accept ? loop_mode : loop_q;
  assign cur_buf  = accept ? msg_arr   : buf_q;

`ifdef SCROLL_DIR_EN
  logic dir_q;

  assign cur_dir  = accept ? dir : dir_q;
  assign char_idx = cur_dir ? (cur_len - LEN_W'(1) - cur_rd) : cur_rd;

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      dir_q <= 1'b0;
    end else if (accept) begin
      dir_q <= dir;
    end
  end
`else
  logic unused_dir;

  assign unused_dir = dir;
  assign cur_dir    = 1'b0;
  assign char_idx   = cur_rd;
`endif

  assign last_char = (cur_rd == (cur_len - LEN_W'(1)));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_d       = rd_q;
    gap_d      = gap_q;
    flush_d    = flush_q;
    loop_d     = loop_q;
    wrap_d     = 1'b0;
    shift_en   = 1'b0;
    shift_code = BLANK_C;
    clear_win  = (state_q == DONE) && !accept;

    if (accept || (step_en && (state_q == RUN_MSG))) begin
      shift_en   = 1'b1;
      shift_code = cur_buf[IDX_W'(char_idx)];
      len_d      = cur_len;
      loop_d     = cur_loop;
      gap_d      = '0;
      flush_d    = '0;
      state_d    = RUN_MSG;
      if (last_char) begin
        rd_d = '0;
        if (!cur_loop) begin
          state_d = FLUSH;
        end else if (GAP > 0) begin
          state_d = RUN_GAP;
        end else begin
          wrap_d = 1'b1;
        end
      end else begin
        rd_d = cur_rd + LEN_W'(1);
      end
    end else if (step_en) begin
      case (state_q)
        RUN_GAP: begin
          shift_en = 1'b1;
          if (gap_q == GAP_W'(GAP - 1)) begin
            gap_d   = '0;
            rd_d    = '0;
            wrap_d  = 1'b1;
            state_d = RUN_MSG;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        FLUSH: begin
          shift_en = 1'b1;
          if (flush_q == FLUSH_W'(DIGITS - 1)) begin
            flush_d = '0;
            state_d = DONE;
          end else begin
            flush_d = flush_q + FLUSH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      rd_q    <= '0;
      gap_q   <= '0;
      flush_q <= '0;
      loop_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      gap_q   <= gap_d;
      flush_q <= flush_d;
      loop_q  <= loop_d;
      wrap_q  <= wrap_d;
      if (accept) begin
        buf_q <= msg_arr;
      end
    end
  end

  scroll_shift_window #(
    .DIGITS (DIGITS),
    .CODE_W (CODE_W),
    .BLANK  (BLANK)
  ) u_window (
    .clk_1hz  (clk_1hz),
    .reset    (reset),
    .en_i     (shift_en),
    .clear_i  (clear_win),
    .dir_i    (cur_dir),
    .code_i   (shift_code),
    .window_o (window)
  );

  assign busy       = (state_q == RUN_MSG) || (state_q == RUN_GAP) || (state_q == FLUSH);
  assign done       = (state_q == DONE);
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_scroll_window_engine.sv
// Scoreboard bench for scroll_window_engine: a stream-position model predicts each step.
// Honours SCROLL_DIR_EN the same way as the design build.
module tb_scroll_window_engine;

  localparam int DIGITS     = 8;
  localparam int CODE_W     = 4;
  localparam int MAX_LEN    = 16;
  localparam int GAP        = 1;
  localparam int BLANK      = 0;
  localparam int AUTO_START = 1;
  localparam int LEN_W      = $clog2(MAX_LEN + 1);
  localparam int WIN_W      = DIGITS * CODE_W;
  localparam logic [CODE_W-1:0] BLANK_C = CODE_W'(BLANK);

  logic                      clk_1hz = 1'b0;
  logic                      reset;
  logic                      start;
  logic                      step_en;
  logic                      loop_mode;
  logic                      dir;
  logic [LEN_W-1:0]          msg_len;
  logic [MAX_LEN*CODE_W-1:0] msg_data;
  logic [WIN_W-1:0]          window;
  logic                      busy;
  logic                      done;
  logic                      wrap_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIN_W-1:0] win;
    logic             busy;
    logic             done;
    logic             wrap;
  } exp_t;

  exp_t sbq[$];

  // Model: mode 0 idle, 1 running, 2 done; mPos is the position within the emitted stream.
  int                mMode;
  int                mPos;
  int                mLen;
  bit                mLoop;
  bit                mDir;
  bit                mWrap;
  logic [CODE_W-1:0] mMsg [MAX_LEN];
  logic [WIN_W-1:0]  mWin;

  always #5 clk_1hz = ~clk_1hz;

  scroll_window_engine #(
    .DIGITS     (DIGITS),
    .CODE_W     (CODE_W),
    .MAX_LEN    (MAX_LEN),
    .GAP        (GAP),
    .BLANK      (BLANK),
    .AUTO_START (AUTO_START)
  ) dut (
    .clk_1hz    (clk_1hz),
    .reset      (reset),
    .start      (start),
    .step_en    (step_en),
    .loop_mode  (loop_mode),
    .dir        (dir),
    .msg_len    (msg_len),
    .msg_data   (msg_data),
    .window     (window),
    .busy       (busy),
    .done       (done),
    .wrap_pulse (wrap_pulse)
  );

  task automatic checkOutput(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode = 0;
    mPos  = 0;
    mWrap = 1'b0;
    mWin  = {DIGITS{BLANK_C}};
  endtask

  task automatic modelEmit();
    int period;
    logic [CODE_W-1:0] sym;
    period = mLoop ? (mLen + GAP) : (mLen + DIGITS);
    if (mPos < mLen) sym = mMsg[mDir ? (mLen - 1 - mPos) : mPos];
    else sym = BLANK_C;
    if (mDir) mWin = {sym, mWin[WIN_W-1:CODE_W]};
    else mWin = {mWin[WIN_W-CODE_W-1:0], sym};
    mPos++;
    if (mPos == period) begin
      mPos = 0;
      if (mLoop) mWrap = 1'b1;
      else mMode = 2;
    end
  endtask

  task automatic modelStep();
    mWrap = 1'b0;
    if (((mMode == 0 && (start || AUTO_START != 0)) || (mMode == 2 && start)) && msg_len != '0) begin
      mLen = (int'(msg_len) > MAX_LEN) ? MAX_LEN : int'(msg_len);
      for (int i = 0; i < MAX_LEN; i++) mMsg[i] = msg_data[i*CODE_W +: CODE_W];
      mLoop = loop_mode;
`ifdef SCROLL_DIR_EN
      mDir = dir;
`else
      mDir = 1'b0;
`endif
      mPos  = 0;
      mMode = 1;
      modelEmit();
    end else if (mMode == 1 && step_en) begin
      modelEmit();
    end
  endtask

  // One clock step: predict from current inputs, push, then pop and compare after the edge.
  task automatic applyStimulus(input string tag);
    exp_t e;
    modelStep();
    e.win  = mWin;
    e.busy = (mMode == 1);
    e.done = (mMode == 2);
    e.wrap = mWrap;
    sbq.push_back(e);
    @(posedge clk_1hz);
    #1;
    e = sbq.pop_front();
    checkOutput({tag, "_win"},  window,     e.win);
    checkOutput({tag, "_busy"}, busy,       e.busy);
    checkOutput({tag, "_done"}, done,       e.done);
    checkOutput({tag, "_wrap"}, wrap_pulse, e.wrap);
  endtask

  initial begin
    int guard;
    reset     = 1'b1;
    start     = 1'b0;
    step_en   = 1'b1;
    loop_mode = 1'b1;
    dir       = 1'b0;
    msg_len   = '0;
    msg_data  = '0;
    modelReset();

    #2;
    checkOutput("rst_win",  window,     '0);
    checkOutput("rst_busy", busy,       '0);
    checkOutput("rst_done", done,       '0);
    checkOutput("rst_wrap", wrap_pulse, '0);
    @(posedge clk_1hz);
    #1;
    checkOutput("rst_hold_win", window, '0);
    #3;
    reset = 1'b0;

    $display("[TB] zero-length message is ignored");
    start = 1'b1;
    repeat (3) applyStimulus("len0");
    start = 1'b0;

    $display("[TB] loop 1..7 with auto start");
    for (int i = 0; i < 7; i++) msg_data[i*CODE_W +: CODE_W] = CODE_W'(i + 1);
    msg_len = LEN_W'(7);
    repeat (8) applyStimulus("loop");
    checkOutput("loop_win8", window, 32'h1234_5670);
    repeat (4) applyStimulus("loop");

    $display("[TB] pause with ignored start and data changes");
    step_en  = 1'b0;
    start    = 1'b1;
    msg_data = {MAX_LEN{4'hF}};
    msg_len  = LEN_W'(2);
    repeat (5) applyStimulus("pause");
    step_en = 1'b1;
    start   = 1'b0;
    repeat (12) applyStimulus("resume");

    $display("[TB] asynchronous reset during the gap");
    guard = 0;
    while (mPos != mLen && guard < 40) begin
      applyStimulus("to_gap");
      guard++;
    end
    msg_len = '0;
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("gaprst_win",  window,     '0);
    checkOutput("gaprst_busy", busy,       '0);
    checkOutput("gaprst_wrap", wrap_pulse, '0);
    #2;
    reset = 1'b0;
    repeat (2) applyStimulus("idle");

    $display("[TB] one-shot A,B,C");
    msg_data = '0;
    msg_data[11:0] = 12'hCBA;
    loop_mode = 1'b0;
    msg_len   = LEN_W'(3);
    repeat (3) applyStimulus("oneshot");
    checkOutput("oneshot_abc", window, 32'h0000_0ABC);
    repeat (8) applyStimulus("flush");
    checkOutput("oneshot_blank", window, '0);
    checkOutput("oneshot_done",  done,   1);
    checkOutput("oneshot_busy",  busy,   0);
    repeat (3) applyStimulus("done_hold");

    $display("[TB] over-length message clamps to MAX_LEN");
    for (int i = 0; i < MAX_LEN; i++) msg_data[i*CODE_W +: CODE_W] = CODE_W'((i % 15) + 1);
    msg_len   = LEN_W'(20);
    loop_mode = 1'b1;
    dir       = 1'b1;
    start     = 1'b1;
    applyStimulus("long_start");
    start = 1'b0;
    dir   = 1'b0;
    repeat (40) applyStimulus("long");

`ifdef SCROLL_DIR_EN
    $display("[TB] reverse direction 1,2,3");
    reset = 1'b1;
    msg_len = '0;
    #1;
    modelReset();
    #2;
    reset = 1'b0;
    msg_data = '0;
    msg_data[11:0] = 12'h321;
    dir     = 1'b1;
    msg_len = LEN_W'(3);
    applyStimulus("rev");
    checkOutput("rev_first", window, 32'h3000_0000);
    applyStimulus("rev");
    checkOutput("rev_second", window, 32'h2300_0000);
    repeat (6) applyStimulus("rev");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
